// File: rtl/tl_ul_mmio_arbiter.sv
// Two-master single-outstanding TL-UL arbiter with round-robin grant.
// Tags A on source {epoch,grant}, drops stray D, issues denied on timeout.
module tl_ul_mmio_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [1:0]  m0_a_size,
  input  logic [31:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m0_a_corrupt,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [1:0]  m0_d_size,
  output logic        m0_d_denied,
  output logic        m0_d_corrupt,
  output logic [31:0] m0_d_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [1:0]  m1_a_size,
  input  logic [31:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  input  logic        m1_a_corrupt,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [1:0]  m1_d_size,
  output logic        m1_d_denied,
  output logic        m1_d_corrupt,
  output logic [31:0] m1_d_data,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [1:0]  s_a_size,
  output logic [1:0]  s_a_source,
  output logic [31:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  output logic        s_a_corrupt,
  output logic        s_a_valid,
  input  logic        s_a_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [1:0]  s_d_size,
  input  logic [1:0]  s_d_source,
  input  logic        s_d_sink,
  input  logic        s_d_denied,
  input  logic [31:0] s_d_data,
  input  logic        s_d_corrupt,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, T_RESP} state_e;

  state_e state_q, state_d;
  logic grant_q, grant_d;
  logic prio_q, prio_d;
  logic epoch_q, epoch_d;
  logic get_q, get_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic a_rdy, d_vld, g_dready, match, unused_sink;
  logic [2:0] d_op;
  logic [1:0] d_par, d_sz;
  logic d_den, d_cor;
  logic [31:0] d_dat;

  assign s_a_opcode  = grant_q ? m1_a_opcode  : m0_a_opcode;
  assign s_a_param   = grant_q ? m1_a_param   : m0_a_param;
  assign s_a_size    = grant_q ? m1_a_size    : m0_a_size;
  assign s_a_address = grant_q ? m1_a_address : m0_a_address;
  assign s_a_mask    = grant_q ? m1_a_mask    : m0_a_mask;
  assign s_a_data    = grant_q ? m1_a_data    : m0_a_data;
  assign s_a_corrupt = grant_q ? m1_a_corrupt : m0_a_corrupt;
  assign s_a_source  = {epoch_q, grant_q};

  assign g_dready    = grant_q ? m1_d_ready : m0_d_ready;
  assign match       = s_d_valid && (s_d_source == {epoch_q, grant_q});
  assign unused_sink = s_d_sink;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    epoch_d   = epoch_q;
    get_d     = get_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    s_a_valid = 1'b0;
    s_d_ready = 1'b1;
    a_rdy     = 1'b0;
    d_vld     = 1'b0;
    d_op      = 3'd0;
    d_par     = 2'd0;
    d_sz      = 2'd0;
    d_den     = 1'b0;
    d_cor     = 1'b0;
    d_dat     = 32'd0;
    unique case (state_q)
      IDLE: begin
        if (m0_a_valid || m1_a_valid) begin
          grant_d = (m0_a_valid && m1_a_valid) ? prio_q : m1_a_valid;
          state_d = A_SEND;
        end
      end
      A_SEND: begin
        s_a_valid = 1'b1;
        a_rdy     = s_a_ready;
        if (s_a_ready) begin
          state_d = D_WAIT;
          cnt_d   = '0;
          get_d   = (s_a_opcode == 3'd4);
        end
      end
      D_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (match) begin
          d_vld     = 1'b1;
          d_op      = s_d_opcode;
          d_par     = s_d_param;
          d_sz      = s_d_size;
          d_den     = s_d_denied;
          d_cor     = s_d_corrupt;
          d_dat     = s_d_data;
          s_d_ready = g_dready;
        end
        if (match && g_dready) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
          epoch_d = ~epoch_q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = T_RESP;
          err_d   = 1'b1;
        end
      end
      T_RESP: begin
        // Locally generated denied reply; slave D is drained meanwhile
        d_vld = 1'b1;
        d_op  = get_q ? 3'd1 : 3'd0;
        d_sz  = 2'd2;
        d_den = 1'b1;
        d_cor = 1'b1;
        if (g_dready) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
          epoch_d = ~epoch_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign m0_a_ready   = a_rdy & ~grant_q;
  assign m1_a_ready   = a_rdy &  grant_q;
  assign m0_d_valid   = d_vld & ~grant_q;
  assign m1_d_valid   = d_vld &  grant_q;
  assign m0_d_opcode  = d_op;
  assign m1_d_opcode  = d_op;
  assign m0_d_param   = d_par;
  assign m1_d_param   = d_par;
  assign m0_d_size    = d_sz;
  assign m1_d_size    = d_sz;
  assign m0_d_denied  = d_den;
  assign m1_d_denied  = d_den;
  assign m0_d_corrupt = d_cor;
  assign m1_d_corrupt = d_cor;
  assign m0_d_data    = d_dat;
  assign m1_d_data    = d_dat;
  assign err_timeout  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
      epoch_q <= 1'b0;
      get_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
      epoch_q <= epoch_d;
      get_q   <= get_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
